// File: rtl/cell_tx_arbiter.sv
// cell_tx_arbiter
//   Round-robin arbiter that shares one cell->buffer message channel among NREQ cell
//   ports. It grants one requesting port, latches the port's {i, j, status} message and
//   offers it to the UART buffer on a valid/ack handshake. A message whose status is 0
//   is a NOP: the port is acknowledged but nothing is sent.
//
// Ports
//   clk        : clock, all state on posedge
//   rst        : synchronous active-high reset
//   req        : per-port request, held with its message until that port's req_ack
//   req_msg    : port k message at [k*MESSAGE_WIDTH +: MESSAGE_WIDTH]
//   req_ack    : one-cycle pulse, port k message taken (sent or dropped as NOP)
//   txmessage  : message presented to the buffer
//   tx_valid   : txmessage is valid
//   tx_ack     : buffer consumed txmessage (only looked at while tx_valid is high)
//   grant_id   : index of the last granted port
//   busy       : high while a message is waiting for tx_ack
//   sent_count : number of forwarded messages, wraps at 16 bits
module cell_tx_arbiter #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned NREQ       = 4,
    localparam int unsigned MESSAGE_WIDTH = 2 * (ADDR_WIDTH + 1) + 4,
    localparam int unsigned GW            = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NREQ-1:0]               req,
    input  logic [NREQ*MESSAGE_WIDTH-1:0] req_msg,
    output logic [NREQ-1:0]               req_ack,
    output logic [MESSAGE_WIDTH-1:0]      txmessage,
    output logic                          tx_valid,
    input  logic                          tx_ack,
    output logic [GW-1:0]                 grant_id,
    output logic                          busy,
    output logic [15:0]                   sent_count
);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e                   state_q, state_d;
    logic [GW-1:0]            rr_q, rr_d;
    logic [NREQ-1:0]          ack_q, ack_d;
    logic [GW-1:0]            grant_q, grant_d;
    logic [MESSAGE_WIDTH-1:0] msg_q, msg_d;
    logic                     valid_q, valid_d;
    logic                     busy_q, busy_d;
    logic [15:0]              cnt_q, cnt_d;

    logic                     found;
    logic [GW-1:0]            pick;
    logic [MESSAGE_WIDTH-1:0] pick_msg;

    // Round-robin scan: first requesting port at or after rr_q, wrapping modulo NREQ.
    always_comb begin
        found    = 1'b0;
        pick     = '0;
        pick_msg = '0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            int unsigned idx;
            idx = (32'(rr_q) + off) % NREQ;
            if (!found && req[idx[GW-1:0]]) begin
                found = 1'b1;
                pick  = idx[GW-1:0];
            end
        end
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (32'(pick) == k) begin
                pick_msg = req_msg[k*MESSAGE_WIDTH +: MESSAGE_WIDTH];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        ack_d   = '0;
        grant_d = grant_q;
        msg_d   = msg_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (found) begin
                    ack_d[pick] = 1'b1;
                    grant_d     = pick;
                    rr_d        = (32'(pick) == NREQ - 1) ? '0 : pick + 1'b1;
                    // NOP messages are acknowledged but never reach the buffer.
                    if (pick_msg[3:0] != 4'h0) begin
                        msg_d   = pick_msg;
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                        state_d = StSend;
                    end
                end
            end
            StSend: begin
                if (tx_ack) begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    cnt_d   = cnt_q + 16'd1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            rr_q    <= '0;
            ack_q   <= '0;
            grant_q <= '0;
            msg_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            ack_q   <= ack_d;
            grant_q <= grant_d;
            msg_q   <= msg_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    assign req_ack    = ack_q;
    assign txmessage  = msg_q;
    assign tx_valid   = valid_q;
    assign grant_id   = grant_q;
    assign busy       = busy_q;
    assign sent_count = cnt_q;

endmodule
